// File: rtl/dcm_pkg.sv
// Shared constants and helpers for the behavioural 50->25 MHz clock manager.
package dcm_pkg;

    localparam int DCM_DEFAULT_LOCK_CYCLES = 32;
    localparam int DCM_MIN_DIVIDE          = 2;
    localparam int DCM_MAX_DIVIDE          = 16;
    localparam int DCM_MAX_LOCK_CYCLES     = 65535;

    // The divider toggles its output once per half period of the divided clock.
    function automatic int half_period_count(input int divide);
        return divide / 2;
    endfunction

    function automatic bit divide_legal(input int divide);
        return (divide >= DCM_MIN_DIVIDE) && (divide <= DCM_MAX_DIVIDE) && (divide % 2 == 0);
    endfunction

endpackage

// File: rtl/dcm_lock_counter.sv
// Saturating post-reset edge counter; raises a sticky lock flag after LOCK_CYCLES edges.
module dcm_lock_counter
    import dcm_pkg::*;
#(
    parameter int LOCK_CYCLES = DCM_DEFAULT_LOCK_CYCLES
) (
    input  logic i_clk50,
    input  logic rst,
    output logic locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    generate
        if (LOCK_CYCLES < 1 || LOCK_CYCLES > DCM_MAX_LOCK_CYCLES) begin : g_bad_lock_cycles
            $error("dcm_lock_counter: LOCK_CYCLES must be in 1..65535");
        end
    endgenerate

    logic [CNT_W-1:0] cnt      = '0;
    logic             locked_q = 1'b0;

    // Flag is set on the same edge that the count reaches LOCK_CYCLES.
    always_ff @(posedge i_clk50) begin
        if (rst) begin
            cnt      <= '0;
            locked_q <= 1'b0;
        end else if (cnt < CNT_W'(LOCK_CYCLES)) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(LOCK_CYCLES - 1))
                locked_q <= 1'b1;
        end
    end

    assign locked = locked_q;

endmodule

// File: rtl/dcm_50to25_mhz.sv
// Behavioural clock manager: buffered/CLK0 copies of the input, a registered
// even-ratio divided clock, and a lock flag gating the divider.
module dcm_50to25_mhz
    import dcm_pkg::*;
#(
    parameter int CLKDV_DIVIDE = 2,
    parameter int LOCK_CYCLES  = DCM_DEFAULT_LOCK_CYCLES
) (
    input  logic CLKIN_IN,
    input  logic RST_IN,
    output logic CLKDV_OUT,
    output logic CLKIN_IBUFG_OUT,
    output logic CLK0_OUT,
    output logic LOCKED_OUT
);

    localparam int HALF  = half_period_count(CLKDV_DIVIDE);
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

    generate
        if (!divide_legal(CLKDV_DIVIDE)) begin : g_bad_divide
            $error("dcm_50to25_mhz: CLKDV_DIVIDE must be an even integer in 2..16");
        end
    endgenerate

    logic             locked;
    logic [DIV_W-1:0] div_cnt = '0;
    logic             clkdv_q = 1'b0;

    dcm_lock_counter #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lock (
        .i_clk50(CLKIN_IN),
        .rst    (RST_IN),
        .locked (locked)
    );

    // Reset is checked explicitly: the lock flag only falls on the reset edge
    // itself, so relying on it alone would let the divider run one edge too long.
    always_ff @(posedge CLKIN_IN) begin
        if (RST_IN || !locked) begin
            div_cnt <= '0;
            clkdv_q <= 1'b0;
        end else if (div_cnt == DIV_W'(HALF - 1)) begin
            div_cnt <= '0;
            clkdv_q <= ~clkdv_q;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign CLKDV_OUT       = clkdv_q;
    assign CLKIN_IBUFG_OUT = CLKIN_IN;
    assign CLK0_OUT        = CLKIN_IN;
    assign LOCKED_OUT      = locked;

endmodule

// File: tb/tb_dcm_50to25_mhz.sv
// Bench for dcm_50to25_mhz: default instance (div 2, lock 32) and a swept
// instance (div 4, lock 5) share clock and reset; a cycle model feeds a scoreboard.
module tb_dcm_50to25_mhz;

    localparam int HALF_T = 10;          // input half period in time units
    localparam int CLK_T  = 2 * HALF_T;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #(HALF_T) clk = ~clk;

    logic dv_a, ibufg_a, clk0_a, lk_a;
    logic dv_b, ibufg_b, clk0_b, lk_b;

    dcm_50to25_mhz dut_a (
        .CLKIN_IN       (clk),
        .RST_IN         (rst),
        .CLKDV_OUT      (dv_a),
        .CLKIN_IBUFG_OUT(ibufg_a),
        .CLK0_OUT       (clk0_a),
        .LOCKED_OUT     (lk_a)
    );

    dcm_50to25_mhz #(
        .CLKDV_DIVIDE(4),
        .LOCK_CYCLES (5)
    ) dut_b (
        .CLKIN_IN       (clk),
        .RST_IN         (rst),
        .CLKDV_OUT      (dv_b),
        .CLKIN_IBUFG_OUT(ibufg_b),
        .CLK0_OUT       (clk0_b),
        .LOCKED_OUT     (lk_b)
    );

    typedef struct {
        logic rst;
        int   cycles;
    } phase_t;

    typedef struct {
        logic lk_a;
        logic dv_a;
        logic lk_b;
        logic dv_b;
    } exp_t;

    int     n_chk  = 0;
    int     n_fail = 0;
    exp_t   sb[$];
    phase_t tbl[6];

    task automatic chk(input string name, input logic act, input logic req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Expected outputs after k edges since reset release.
    function automatic void model(input int k, input int lc, input int half,
                                  output logic lk, output logic dv);
        lk = (k >= lc);
        dv = 1'b0;
        if (lk)
            dv = (((k - lc) / half) % 2) == 1;
    endfunction

    // Measure divided-clock periods and high times from posedge-sampled values.
    task automatic measure(input int n_cycles, input int max_periods_a);
        int   rise_a = -1, rise_b = -1, per_a = 0;
        logic prev_a, prev_b;
        int   now;
        prev_a = dv_a;
        prev_b = dv_b;
        for (int c = 0; c < n_cycles; c++) begin
            @(posedge clk);
            #1;
            now = int'($time);
            if (dv_a && !prev_a) begin
                if (rise_a >= 0 && per_a < max_periods_a) begin
                    chk_int("period_a", now - rise_a, 2 * CLK_T);
                    per_a++;
                end
                rise_a = now;
            end
            if (!dv_a && prev_a && rise_a >= 0)
                chk_int("high_a", now - rise_a, CLK_T);
            if (dv_b && !prev_b) begin
                if (rise_b >= 0)
                    chk_int("period_b", now - rise_b, 4 * CLK_T);
                rise_b = now;
            end
            if (!dv_b && prev_b && rise_b >= 0)
                chk_int("high_b", now - rise_b, 2 * CLK_T);
            prev_a = dv_a;
            prev_b = dv_b;
        end
        chk_int("periods_a_seen", per_a, max_periods_a);
    endtask

    initial begin
        int   k;
        exp_t e;
        exp_t got;

        tbl[0] = '{rst: 1'b1, cycles: 4};    // power-up reset
        tbl[1] = '{rst: 1'b0, cycles: 40};   // lock and run
        tbl[2] = '{rst: 1'b1, cycles: 1};    // mid-run reset pulse
        tbl[3] = '{rst: 1'b0, cycles: 40};   // relock
        tbl[4] = '{rst: 1'b1, cycles: 100};  // reset held
        tbl[5] = '{rst: 1'b0, cycles: 50};   // release again

        k = 0;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < tbl[p].cycles; c++) begin
                @(negedge clk);
                #1;
                chk("clk0_low", clk0_a, clk);
                chk("ibufg_low", ibufg_b, clk);
                rst = tbl[p].rst;
                if (tbl[p].rst) begin
                    k = 0;
                    e = '{lk_a: 1'b0, dv_a: 1'b0, lk_b: 1'b0, dv_b: 1'b0};
                end else begin
                    k++;
                    model(k, 32, 1, e.lk_a, e.dv_a);
                    model(k, 5, 2, e.lk_b, e.dv_b);
                end
                sb.push_back(e);

                @(posedge clk);
                #1;
                got = sb.pop_front();
                chk("locked_a", lk_a, got.lk_a);
                chk("clkdv_a", dv_a, got.dv_a);
                chk("locked_b", lk_b, got.lk_b);
                chk("clkdv_b", dv_b, got.dv_b);
                chk("clk0_high", clk0_b, clk);
                chk("ibufg_high", ibufg_a, clk);
            end
        end

        chk_int("scoreboard_empty", sb.size(), 0);

        // Both instances are locked here; check 100 full divided periods.
        measure(204, 100);

        // Single-edge reset while running: both outputs fall on that edge.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pulse_locked_a", lk_a, 1'b0);
        chk("rst_pulse_clkdv_a", dv_a, 1'b0);
        chk("rst_pulse_locked_b", lk_b, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) chk("relock_b_edge4", lk_b, 1'b0);
            if (c == 5) chk("relock_b_edge5", lk_b, 1'b1);
            if (c == 31) chk("relock_a_edge31", lk_a, 1'b0);
            if (c == 32) chk("relock_a_edge32", lk_a, 1'b1);
        end
        @(posedge clk);
        #1;
        chk("first_rise_a", dv_a, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog so a stalled run still terminates.
    initial begin
        #(CLK_T * 5000);
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
